// File: rtl/desc_seed_sched.sv
// Round-robin keypoint scheduler that launches one seed-address sweep per keypoint.
// Optional sweep watchdog is enabled by defining SEED_TIMEOUT_EN.
module desc_seed_sched #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_DW    = 16,
  parameter int NUM_WAIT  = 2,
  parameter int NUM_SEED  = 249,
  parameter int TO_MARGIN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CNT_DW-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      stall,
  output logic                      gen_start,
  output logic [CNT_DW-1:0]         gen_base,
  output logic [2:0]                gen_id,
  input  logic                      gen_done,
  output logic                      gen_abort,
  output logic                      busy,
  output logic [CNT_DW-1:0]         kp_done,
  output logic                      err,
  output logic [1:0]                dbg_state
);

  // Handshake: a queue holds req_valid and its address stable until it sees
  // req_ready, a one-cycle pop pulse issued together with gen_start.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int GAP_W = (NUM_WAIT > 1) ? $clog2(NUM_WAIT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((NUM_WAIT > 0) ? NUM_WAIT - 1 : 0);
  localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_SEED < 1 || TO_MARGIN < 0) begin : g_param_check
    $error("desc_seed_sched: parameter out of range");
  end

  state_t               state_q, state_d;
  logic [2:0]           last_q, last_d;
  logic [CNT_DW-1:0]    base_q, base_d;
  logic [2:0]           id_q, id_d;
  logic                 start_q, start_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [CNT_DW-1:0]    kp_q, kp_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 busy_q, busy_d;

`ifdef SEED_TIMEOUT_EN
  localparam int WD_LIMIT = NUM_SEED + TO_MARGIN;
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            abort_q, abort_d;
  logic            err_q, err_d;
`endif

  logic                 found;
  logic [2:0]           pick;
  logic [CNT_DW-1:0]    pick_addr;
  logic [NUM_REQ-1:0]   pick_oh;

  // Search last+1, last+2, ... wrapping; candidate for step k is i == (last+k) mod NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(last_q) + k == i) || (int'(last_q) + k == i + NUM_REQ))) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    pick_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == 3'(i)) begin
        pick_addr  = req_addr[i*CNT_DW +: CNT_DW];
        pick_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    base_d  = base_q;
    id_d    = id_q;
    start_d = 1'b0;
    ready_d = '0;
    kp_d    = kp_q;
    gap_d   = gap_q;
`ifdef SEED_TIMEOUT_EN
    wd_d    = wd_q;
    abort_d = 1'b0;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found && !stall) begin
          state_d = S_LOAD;
          base_d  = pick_addr;
          id_d    = pick;
          last_d  = pick;
          start_d = 1'b1;
          ready_d = pick_oh;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
`ifdef SEED_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_RUN: begin
        if (gen_done) begin
          kp_d    = kp_q + CNT_DW'(1);
          state_d = (NUM_WAIT > 0) ? S_GAP : S_IDLE;
          gap_d   = '0;
        end
`ifdef SEED_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          // A zero-length gap makes GAP equivalent to returning to IDLE directly.
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = (NUM_WAIT > 0) ? S_GAP : S_IDLE;
          gap_d   = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      base_q  <= '0;
      id_q    <= '0;
      start_q <= 1'b0;
      ready_q <= '0;
      kp_q    <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
`ifdef SEED_TIMEOUT_EN
      wd_q    <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      base_q  <= base_d;
      id_q    <= id_d;
      start_q <= start_d;
      ready_q <= ready_d;
      kp_q    <= kp_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
`ifdef SEED_TIMEOUT_EN
      wd_q    <= wd_d;
      abort_q <= abort_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign gen_start = start_q;
  assign gen_base  = base_q;
  assign gen_id    = id_q;
  assign busy      = busy_q;
  assign kp_done   = kp_q;
  assign dbg_state = state_q;

`ifdef SEED_TIMEOUT_EN
  assign gen_abort = abort_q;
  assign err       = err_q;
`else
  assign gen_abort = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_desc_seed_sched.sv
// Bench for desc_seed_sched: random keypoint traffic against a round-robin reference model.
module tb_desc_seed_sched;
  localparam int NW     = 2;
  localparam int TO_LIM = 249 + 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_addr;
  logic [3:0]  req_ready;
  logic        stall, gen_start, gen_done, gen_abort, busy, err;
  logic [15:0] gen_base, kp_done;
  logic [2:0]  gen_id;
  logic [1:0]  dbg_state;

  logic        rst_z;
  logic [3:0]  req_valid_z;
  logic [63:0] req_addr_z;
  logic [3:0]  req_ready_z;
  logic        stall_z, gen_start_z, gen_done_z, gen_abort_z, busy_z, err_z;
  logic [15:0] gen_base_z, kp_done_z;
  logic [2:0]  gen_id_z;
  logic [1:0]  dbg_state_z;

  desc_seed_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .stall(stall), .gen_start(gen_start),
    .gen_base(gen_base), .gen_id(gen_id), .gen_done(gen_done),
    .gen_abort(gen_abort), .busy(busy), .kp_done(kp_done), .err(err),
    .dbg_state(dbg_state)
  );

  desc_seed_sched #(.NUM_WAIT(0)) dut_z (
    .clk(clk), .rst(rst_z), .req_valid(req_valid_z), .req_addr(req_addr_z),
    .req_ready(req_ready_z), .stall(stall_z), .gen_start(gen_start_z),
    .gen_base(gen_base_z), .gen_id(gen_id_z), .gen_done(gen_done_z),
    .gen_abort(gen_abort_z), .busy(busy_z), .kp_done(kp_done_z), .err(err_z),
    .dbg_state(dbg_state_z)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          ref_last;
  int          ref_kp;
  logic [18:0] exp_q[$];
  logic [2:0]  cur_id;
  logic [15:0] cur_base;

  function automatic int ref_pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [15:0] slot(input logic [63:0] a, input int i);
    return a[i*16 +: 16];
  endfunction

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; stall = 1'b0; gen_done = 1'b0;
    repeat (2) nedge();
    rst = 1'b0;
    ref_last = 3; ref_kp = 0;
    exp_q.delete();
  endtask

  // Waits (bounded) for a launch and checks it against the model's grant choice.
  task automatic expect_start(input int max_wait, input bit keep, output int waited);
    logic [18:0] e;
    int p;
    p = ref_pick(ref_last, req_valid);
    if (p >= 0) exp_q.push_back({3'(p), slot(req_addr, p)});
    waited = 0;
    while (!gen_start && waited < max_wait) begin
      nedge();
      waited++;
    end
    n_cmp++;
    if (gen_start !== 1'b1 || p < 0) begin
      n_err++;
      $display("FAIL start_seen: got gen_start=%b after %0d cycles, want 1", gen_start, waited);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (gen_id !== e[18:16]) begin
      n_err++; $display("FAIL grant_id: got %0d want %0d", gen_id, e[18:16]);
    end
    n_cmp++;
    if (gen_base !== e[15:0]) begin
      n_err++; $display("FAIL grant_base: got %h want %h", gen_base, e[15:0]);
    end
    n_cmp++;
    if (req_ready !== (4'b0001 << e[18:16])) begin
      n_err++; $display("FAIL pop_onehot: got %b want %b", req_ready, 4'b0001 << e[18:16]);
    end
    ref_last = p; cur_id = e[18:16]; cur_base = e[15:0];
    if (keep) req_addr[p*16 +: 16] = 16'($urandom);
    else req_valid[p] = 1'b0;
  endtask

  // Called at the launch cycle; completes the sweep after len cycles (len >= 2).
  task automatic finish_sweep(input int len);
    repeat (len - 1) nedge();
    n_cmp++;
    if (gen_base !== cur_base || gen_id !== cur_id || busy !== 1'b1) begin
      n_err++;
      $display("FAIL hold_in_run: got base=%h id=%0d busy=%b want base=%h id=%0d busy=1",
               gen_base, gen_id, busy, cur_base, cur_id);
    end
    stall = 1'b0;
    gen_done = 1'b1;
    nedge();
    gen_done = 1'b0;
    ref_kp++;
    n_cmp++;
    if (kp_done !== 16'(ref_kp)) begin
      n_err++; $display("FAIL kp_done: got %0d want %0d", kp_done, ref_kp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (gen_start !== 1'b0 || req_ready !== 4'b0 || gen_abort !== 1'b0 || gen_base !== 16'h0 ||
        gen_id !== 3'd0 || busy !== 1'b0 || kp_done !== 16'h0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got start=%b ready=%b abort=%b base=%h id=%0d busy=%b kp=%0d err=%b want all 0",
               gen_start, req_ready, gen_abort, gen_base, gen_id, busy, kp_done, err);
    end
  endtask

  task automatic test_single();
    int w;
    apply_reset();
    req_addr[15:0] = 16'h1234;
    req_valid = 4'b0001;
    expect_start(20, 1'b0, w);
    n_cmp++;
    if (w !== 1) begin n_err++; $display("FAIL first_latency: got %0d want 1", w); end
    finish_sweep(249);
    req_addr[15:0] = 16'h5678;
    req_valid = 4'b0001;
    expect_start(20, 1'b0, w);
    n_cmp++;
    if (w !== NW + 1) begin n_err++; $display("FAIL gap_latency: got %0d want %0d", w, NW + 1); end
    finish_sweep(5);
  endtask

  task automatic test_fairness();
    int w;
    apply_reset();
    for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = 16'($urandom);
    req_valid = 4'b1111;
    for (int r = 0; r < 8; r++) begin
      expect_start(20, 1'b1, w);
      finish_sweep(10);
    end
    n_cmp++;
    if (kp_done !== 16'd8) begin n_err++; $display("FAIL fair_count: got %0d want 8", kp_done); end
  endtask

  task automatic test_stall();
    int w;
    apply_reset();
    stall = 1'b1;
    req_addr[47:32] = 16'($urandom);
    req_valid = 4'b0100;
    repeat (5) begin
      nedge();
      n_cmp++;
      if (gen_start !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL stall_block: got start=%b busy=%b want 0 0", gen_start, busy);
      end
    end
    stall = 1'b0;
    expect_start(20, 1'b0, w);
    n_cmp++;
    if (w !== 1) begin n_err++; $display("FAIL stall_release: got %0d want 1", w); end
    repeat (2) nedge();
    stall = 1'b1;
    finish_sweep(8);
  endtask

  task automatic test_spurious_and_reset();
    int w;
    apply_reset();
    nedge();
    gen_done = 1'b1; nedge(); gen_done = 1'b0; nedge();
    n_cmp++;
    if (kp_done !== 16'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL done_in_idle: got kp=%0d busy=%b want 0 0", kp_done, busy);
    end
    req_addr[47:32] = 16'($urandom);
    req_valid = 4'b0100;
    expect_start(20, 1'b0, w);
    finish_sweep(4);
    req_addr[63:48] = 16'($urandom);
    req_valid = 4'b1000;
    expect_start(20, 1'b0, w);
    gen_done = 1'b1;
    nedge();
    gen_done = 1'b0;
    n_cmp++;
    if (kp_done !== 16'd1 || busy !== 1'b1 || dbg_state !== 2'd2) begin
      n_err++;
      $display("FAIL done_in_load: got kp=%0d busy=%b state=%0d want 1 1 2", kp_done, busy, dbg_state);
    end
    repeat (3) nedge();
    rst = 1'b1;
    req_valid = 4'b1111;
    nedge();
    n_cmp++;
    if (busy !== 1'b0 || kp_done !== 16'd0 || gen_id !== 3'd0 || gen_start !== 1'b0 || req_ready !== 4'b0) begin
      n_err++;
      $display("FAIL mid_run_reset: got busy=%b kp=%0d id=%0d start=%b ready=%b want all 0",
               busy, kp_done, gen_id, gen_start, req_ready);
    end
    rst = 1'b0;
    ref_last = 3; ref_kp = 0;
    expect_start(20, 1'b0, w);
    finish_sweep(3);
  endtask

  task automatic test_random();
    int w, spur, exp_w;
    logic [3:0] add;
    apply_reset();
    spur = 0;
    for (int r = 0; r < 14; r++) begin
      add = 4'($urandom_range(0, 15)) & ~req_valid;
      if ((req_valid | add) == 4'b0) add = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) if (add[i]) req_addr[i*16 +: 16] = 16'($urandom);
      req_valid = req_valid | add;
      exp_w = (r == 0) ? 1 : NW + 1 - spur;
      expect_start(30, 1'b0, w);
      n_cmp++;
      if (w !== exp_w) begin n_err++; $display("FAIL rand_latency: got %0d want %0d", w, exp_w); end
      if ($urandom_range(0, 1) == 1) stall = 1'b1;
      finish_sweep($urandom_range(2, 20));
      spur = $urandom_range(0, 1);
      if (spur == 1) begin
        gen_done = 1'b1; nedge(); gen_done = 1'b0;
      end
    end
  endtask

  task automatic test_no_gap();
    int w;
    rst_z = 1'b1; req_valid_z = '0; stall_z = 1'b0; gen_done_z = 1'b0;
    repeat (2) nedge();
    rst_z = 1'b0;
    req_addr_z[15:0] = 16'($urandom);
    req_addr_z[31:16] = 16'($urandom);
    req_valid_z = 4'b0011;
    w = 0;
    while (!gen_start_z && w < 20) begin nedge(); w++; end
    n_cmp++;
    if (gen_start_z !== 1'b1 || gen_id_z !== 3'd0 || gen_base_z !== req_addr_z[15:0] || req_ready_z !== 4'b0001) begin
      n_err++; $display("FAIL nogap_first: got start=%b id=%0d base=%h want 1 0 %h",
                        gen_start_z, gen_id_z, gen_base_z, req_addr_z[15:0]);
    end
    req_valid_z[0] = 1'b0;
    repeat (4) nedge();
    gen_done_z = 1'b1; nedge(); gen_done_z = 1'b0;
    n_cmp++;
    if (busy_z !== 1'b0 || kp_done_z !== 16'd1 || gen_start_z !== 1'b0) begin
      n_err++; $display("FAIL nogap_idle: got busy=%b kp=%0d start=%b want 0 1 0", busy_z, kp_done_z, gen_start_z);
    end
    nedge();
    n_cmp++;
    if (gen_start_z !== 1'b1 || gen_id_z !== 3'd1 || gen_base_z !== req_addr_z[31:16]) begin
      n_err++; $display("FAIL nogap_second: got start=%b id=%0d base=%h want 1 1 %h",
                        gen_start_z, gen_id_z, gen_base_z, req_addr_z[31:16]);
    end
    req_valid_z[1] = 1'b0;
    repeat (3) nedge();
    gen_done_z = 1'b1; nedge(); gen_done_z = 1'b0;
    n_cmp++;
    if (kp_done_z !== 16'd2 || err_z !== 1'b0) begin
      n_err++; $display("FAIL nogap_count: got kp=%0d err=%b want 2 0", kp_done_z, err_z);
    end
  endtask

  task automatic test_timeout();
    int w, k;
    apply_reset();
    req_addr[15:0] = 16'($urandom);
    req_valid = 4'b0001;
    expect_start(20, 1'b0, w);
`ifdef SEED_TIMEOUT_EN
    k = 0;
    while (k < TO_LIM + 20) begin
      nedge(); k++;
      if (gen_abort === 1'b1) break;
    end
    n_cmp++;
    if (k !== TO_LIM + 1 || gen_abort !== 1'b1) begin
      n_err++; $display("FAIL abort_time: got abort=%b at %0d want 1 at %0d", gen_abort, k, TO_LIM + 1);
    end
    n_cmp++;
    if (err !== 1'b1 || kp_done !== 16'd0) begin
      n_err++; $display("FAIL abort_state: got err=%b kp=%0d want 1 0", err, kp_done);
    end
    nedge();
    n_cmp++;
    if (gen_abort !== 1'b0 || err !== 1'b1) begin
      n_err++; $display("FAIL abort_pulse: got abort=%b err=%b want 0 1", gen_abort, err);
    end
    repeat (4) nedge();
    req_addr[31:16] = 16'($urandom);
    req_valid = 4'b0010;
    expect_start(20, 1'b0, w);
    repeat (TO_LIM) nedge();
    gen_done = 1'b1; nedge(); gen_done = 1'b0;
    ref_kp++;
    n_cmp++;
    if (gen_abort !== 1'b0 || kp_done !== 16'(ref_kp) || err !== 1'b1) begin
      n_err++; $display("FAIL done_beats_abort: got abort=%b kp=%0d err=%b want 0 %0d 1",
                        gen_abort, kp_done, err, ref_kp);
    end
`else
    k = 0;
    repeat (TO_LIM + 40) begin
      nedge();
      if (gen_abort !== 1'b0) k++;
    end
    n_cmp++;
    if (k !== 0 || dbg_state !== 2'd2 || busy !== 1'b1 || err !== 1'b0) begin
      n_err++; $display("FAIL no_watchdog: got aborts=%0d state=%0d busy=%b err=%b want 0 2 1 0",
                        k, dbg_state, busy, err);
    end
    finish_sweep(2);
`endif
  endtask

  initial begin
    rst_z = 1'b1; req_valid_z = '0; req_addr_z = '0; stall_z = 1'b0; gen_done_z = 1'b0;
    rst = 1'b1; req_valid = '0; req_addr = '0; stall = 1'b0; gen_done = 1'b0;
    nedge();
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_spurious_and_reset();
    test_random();
    test_no_gap();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
